day_1_parser: RTL and testbench
===============================

# day_1_parser

Upstream stage of the day 1 dial solver. It receives the puzzle input as an ASCII byte stream, one rotation per line (for example `L68`, `R48`), and converts each line into an 11-bit rotation op word. The solver consumes these words in order, so the parser turns raw text into the packed op format with no software preprocessing. The parser also counts ops, flags malformed input, and signals end of stream.

## Interface
Parameters:
- `AMT_W`, default 10: width of the rotation amount field. The op word is `AMT_W+1` bits.
- `CNT_W`, default 16: width of `op_count`.

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: `in_byte` is valid.
- `in_ready`, out, 1: the parser accepts a byte this cycle.
- `in_byte`, in, 8: ASCII character.
- `in_last`, in, 1: qualifies the final byte of the stream.
- `op_valid`, out, 1: `op_data` holds a completed op.
- `op_ready`, in, 1: the downstream stage takes the op.
- `op_data`, out, `AMT_W+1`: bit `[AMT_W]` is the direction (1 = `R`, 0 = `L`); bits `[AMT_W-1:0]` are the unsigned amount.
- `op_count`, out, `CNT_W`: number of ops emitted so far.
- `done`, out, 1: stream fully parsed. Sticky until reset.
- `err`, out, 1: malformed input seen. Sticky until reset.

## Operation
- A byte is accepted when `in_valid && in_ready`.
- States:
  - `S_DIR`: waiting for a direction letter.
  - `S_NUM`: accumulating digits.
  - `S_ERR`: draining after bad input.
  - `S_DONE`: stream finished.
- In `S_DIR`:
  - `'R'` or `'L'` latches the direction, clears `amt` and `ndig`, and moves to `S_NUM`.
  - `'\n'` and `'\r'` are ignored, so blank lines are allowed.
  - Any other byte moves to `S_ERR`.
- In `S_NUM`:
  - A digit `'0'`–`'9'` sets `amt = amt*10 + digit` and increments `ndig`.
  - `amt` is computed at `AMT_W+4` bits internally. A result above `2^AMT_W - 1` moves to `S_ERR`.
  - `'\r'` is ignored.
  - `'\n'` with `ndig > 0` emits the op and moves to `S_DIR`. With `ndig == 0` it moves to `S_ERR`.
  - Any other byte moves to `S_ERR`.
- Emitting an op:
  - Loads `op_data = {dir, amt[AMT_W-1:0]}`, sets `op_valid`, and increments `op_count`.
  - `op_count` wraps modulo `2^CNT_W`.
- Accepting a byte with `in_last`:
  - Finishes the pending line as if `'\n'` followed. This emits an op if in `S_NUM` with `ndig > 0`. If in `S_NUM` with `ndig == 0`, it sets `err`.
  - Then moves to `S_DONE`.
  - If the `in_last` byte is itself `'\n'`, only one emission occurs.
- `S_ERR`:
  - Sets `err`.
  - `in_ready` stays high, and all bytes are discarded until `in_last`, then the state moves to `S_DONE`.
  - No further ops are emitted.
- `S_DONE`:
  - `done` is high and `in_ready` is low.
  - Only reset leaves this state.
- Reset, including mid-line or mid-handshake:
  - State goes to `S_DIR`, and `amt`, `ndig`, and `dir` clear.
  - Outputs go low: `op_valid`, `op_data`, `op_count`, `done`, `err`, and `in_ready`.
  - A partial line is lost.

## Timing
- Reset values:
  - While `rst_n` is low, `in_ready` is 0.
  - All other outputs are 0.
  - `in_ready` rises in the first cycle after reset deassertion.
- Throughput is one byte per cycle.
- Latency: if the terminating `'\n'` (or the `in_last` byte) is accepted in cycle N, `op_valid` is high in cycle N+1.
- There is a single output register with no skid buffer:
  - `in_ready = (state != S_DONE) && !(op_valid && !op_ready)`.
  - A stalled op therefore blocks input.
  - An op held under backpressure keeps `op_valid` and `op_data` stable until it is taken.
- `op_valid` clears on `op_valid && op_ready`, unless a new op loads in the same cycle, in which case it stays high with the new data. Back-to-back ops need no bubble.
- `done` rises the cycle after the `in_last` byte is accepted. It does not wait for the final op to be taken; downstream must still drain `op_valid`.

## Structure
- Package `day_1_pkg` holds:
  - Shared constants: `AMT_W` and the op field positions (`OP_DIR_BIT`, `OP_AMT_MSB`).
  - The ASCII constants: `'R'`, `'L'`, `'0'`, `'9'`, LF, CR.
  - The state enum.
- One sub-module, `day_1_op_reg`, is the single-entry valid/ready output register. It is kept separate for reuse by later day parsers.
- The decimal accumulate uses shift-add (`amt<<3 + amt<<1`). There is no multiplier.

## Test plan
- Bytes `"R48\n"`: `op_data = 0x430` once, `op_count = 1`, `err = 0`.
- Bytes `"L68\nR0\n\nL5"` with `in_last` on `'5'`: ops `0x044`, `0x400`, `0x005` in order. Then `done = 1`, `op_count = 3`, `err = 0`.
- Same stream with `op_ready` held low for 10 cycles after the first op:
  - `in_ready` stays low throughout, and `op_data` holds `0x044`.
  - All three ops arrive in order, with no loss or duplication.
- `"R1024\n"` then `"L1\n"` with `in_last` on the final LF: `err = 1`, zero ops emitted, `done = 1` after the last byte.
- `"X7\n"` and `"R\n"`: `err = 1` for each case (reset between cases), with no op emitted.
- `rst_n` pulsed low mid-line after `"R12"`, then `"L3\n"`: the only op is `0x003`, and `op_count = 1`.

Source files
------------

// File: rtl/day_1_pkg.sv
// Shared constants, ASCII codes and parser state type for the day 1 dial solver front end.
package day_1_pkg;
  localparam int AMT_W      = 10;
  localparam int OP_DIR_BIT = AMT_W;
  localparam int OP_AMT_MSB = AMT_W - 1;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_DIR  = 2'd0,
    S_NUM  = 2'd1,
    S_ERR  = 2'd2,
    S_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/day_1_op_reg.sv
// Single-entry valid/ready output register; a load may replace an entry that is being taken.
module day_1_op_reg #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/day_1_parser.sv
// ASCII rotation-line parser: turns "L68\n"-style lines into {dir, amt} op words.
//   state  | meaning
//   S_DIR  | waiting for a direction letter (CR/LF skipped)
//   S_NUM  | accumulating decimal digits of the amount
//   S_ERR  | malformed input seen, discarding until in_last
//   S_DONE | stream finished, input closed until reset
module day_1_parser
  #(
  parameter int AMT_W = day_1_pkg::AMT_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [AMT_W:0]   op_data,
  output logic [CNT_W-1:0] op_count,
  output logic             done,
  output logic             err
);
  import day_1_pkg::*;

  localparam int ACC_W = AMT_W + 4;
  localparam logic [ACC_W-1:0] AMT_MAX = ACC_W'((1 << AMT_W) - 1);

  state_e           state, state_n;
  logic             dir, dir_n;
  logic [AMT_W-1:0] amt, amt_n;
  logic [3:0]       ndig, ndig_n;
  logic             rdy_en;
  logic             accept, emit, err_hit, is_digit;
  logic [ACC_W-1:0] amt_x, acc;

  assign in_ready = rdy_en && (state != S_DONE) && !(op_valid && !op_ready);
  assign accept   = in_valid && in_ready;
  assign done     = (state == S_DONE);
  assign is_digit = (in_byte >= CH_0) && (in_byte <= CH_9);

  // amt*10 + digit via shift-add; the extra 4 bits catch overflow past AMT_W
  assign amt_x = {4'b0000, amt};
  assign acc   = (amt_x << 3) + (amt_x << 1) + {{AMT_W{1'b0}}, in_byte[3:0]};

  always_comb begin
    state_n = state;
    dir_n   = dir;
    amt_n   = amt;
    ndig_n  = ndig;
    emit    = 1'b0;
    err_hit = 1'b0;
    if (accept) begin
      case (state)
        S_DIR: begin
          if (in_byte == CH_R || in_byte == CH_L) begin
            dir_n   = (in_byte == CH_R);
            amt_n   = '0;
            ndig_n  = '0;
            state_n = S_NUM;
          end else if (in_byte != CH_LF && in_byte != CH_CR) begin
            state_n = S_ERR;
            err_hit = 1'b1;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            if (acc > AMT_MAX) begin
              state_n = S_ERR;
              err_hit = 1'b1;
            end else begin
              amt_n  = acc[AMT_W-1:0];
              ndig_n = (ndig == 4'hF) ? ndig : ndig + 4'd1;
            end
          end else if (in_byte == CH_LF) begin
            if (ndig != 4'd0) begin
              emit    = 1'b1;
              state_n = S_DIR;
            end else begin
              state_n = S_ERR;
              err_hit = 1'b1;
            end
          end else if (in_byte != CH_CR) begin
            state_n = S_ERR;
            err_hit = 1'b1;
          end
        end
        default: ;
      endcase
      // in_last closes the pending line as if an LF followed it
      if (in_last) begin
        if (state_n == S_NUM) begin
          if (ndig_n != 4'd0) emit = 1'b1;
          else                err_hit = 1'b1;
        end
        state_n = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_DIR;
      dir      <= 1'b0;
      amt      <= '0;
      ndig     <= '0;
      rdy_en   <= 1'b0;
      err      <= 1'b0;
      op_count <= '0;
    end else begin
      state  <= state_n;
      dir    <= dir_n;
      amt    <= amt_n;
      ndig   <= ndig_n;
      rdy_en <= 1'b1;
      if (err_hit) err <= 1'b1;
      if (emit) op_count <= op_count + 1'b1;
    end
  end

  day_1_op_reg #(.W(AMT_W + 1)) u_op_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (emit),
    .load_data ({dir_n, amt_n}),
    .ready     (op_ready),
    .valid     (op_valid),
    .data      (op_data)
  );

endmodule

// File: tb/tb_day_1_parser.sv
// Directed-vector bench for day_1_parser with a queue scoreboard and an independent op monitor.
module tb_day_1_parser;
  import day_1_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;
  logic        in_last = 1'b0;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [10:0] op_data;
  logic [15:0] op_count;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  day_1_parser #(.AMT_W(10), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .in_last  (in_last),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_data  (op_data),
    .op_count (op_count),
    .done     (done),
    .err      (err)
  );

  function automatic logic [10:0] mkop(input bit d, input int a);
    logic [10:0] o;
    o = '0;
    o[OP_DIR_BIT] = d;
    o[OP_AMT_MSB:0] = a[OP_AMT_MSB:0];
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when valid&&ready seen here
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && op_valid && op_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL op_unexpected: got %h expected none", op_data);
        end else begin
          e = exp_q.pop_front();
          if (op_data !== e) begin
            errors++;
            $display("FAIL op_data: got %h expected %h", op_data, e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outputs", {12'd0, op_valid, done, err, op_count, op_data[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    forever begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        break;
      end
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL send_timeout: byte %h not accepted within 200 cycles", b);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_str(input string s, input bit last_on_final);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last_on_final && (i == s.len() - 1));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("op_valid_idle", {31'd0, op_valid}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Single line
    do_reset();
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(11'h430);
    send_str("R48\n", 1'b0);
    drain();
    chk("t1_count", op_count, 32'd1);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_done", {31'd0, done}, 32'd0);

    // Multi-line stream, blank line, in_last on digit
    do_reset();
    exp_q.push_back(11'h044);
    exp_q.push_back(11'h400);
    exp_q.push_back(11'h005);
    send_str("L68\nR0\n\nL5", 1'b1);
    drain();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_count", op_count, 32'd3);
    chk("t2_err", {31'd0, err}, 32'd0);
    chk("t2_in_ready_done", {31'd0, in_ready}, 32'd0);

    // Same stream with backpressure on the first op
    do_reset();
    op_ready = 1'b0;
    exp_q.push_back(mkop(1'b0, 68));
    exp_q.push_back(mkop(1'b1, 0));
    exp_q.push_back(mkop(1'b0, 5));
    fork
      send_str("L68\nR0\n\nL5", 1'b1);
      begin
        int n;
        n = 0;
        while (!op_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (!op_valid) begin
          errors++;
          $display("FAIL stall_wait: op_valid 0 expected 1 within 100 cycles");
        end
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          #3;
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          chk("stall_op_data", {21'd0, op_data}, 32'h044);
        end
        @(negedge clk);
        op_ready = 1'b1;
      end
    join
    drain();
    chk("t3_count", op_count, 32'd3);
    chk("t3_done", {31'd0, done}, 32'd1);

    // Amount overflow, rest discarded until in_last
    do_reset();
    send_str("R1024\nL1\n", 1'b1);
    drain();
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_count", op_count, 32'd0);
    chk("t4_done", {31'd0, done}, 32'd1);

    // Bad direction letter
    do_reset();
    send_str("X7\n", 1'b1);
    drain();
    chk("t5a_err", {31'd0, err}, 32'd1);
    chk("t5a_count", op_count, 32'd0);

    // Direction with no digits
    do_reset();
    send_str("R\n", 1'b1);
    drain();
    chk("t5b_err", {31'd0, err}, 32'd1);
    chk("t5b_count", op_count, 32'd0);

    // Reset mid-line drops the partial line
    do_reset();
    send("R", 1'b0);
    send("1", 1'b0);
    send("2", 1'b0);
    do_reset();
    chk("t6_count_after_rst", op_count, 32'd0);
    exp_q.push_back(11'h003);
    send_str("L3\n", 1'b0);
    drain();
    chk("t6_count", op_count, 32'd1);
    chk("t6_err", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
